rsa_modexp_ctrl: RTL and testbench

Sequencer that computes cipht = plaint^exp mod n by driving a shared modular multiplier (a*b mod n) through right-to-left binary square-and-multiply. It sits between the RSA_top request interface (plaint/in_vaild/ready/vaild/cipht) and the multiplier core. It owns the operand/result registers and the exponent-bit scheduling.

---
 rtl/rsa_modexp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving a shared (a*b mod n) multiplier.
// Define RSA_MODEXP_EARLY_EXIT_EN to skip dummy multiplies and stop after the top exponent bit.
module rsa_modexp_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vaild,
    input  logic [WIDTH-1:0] plaint,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             vaild,
    output logic [WIDTH-1:0] cipht,
    output logic             err,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_MUL      = 3'd2;
    localparam logic [2:0] S_MUL_WAIT = 3'd3;
    localparam logic [2:0] S_SQR      = 3'd4;
    localparam logic [2:0] S_SQR_WAIT = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_e_sh;
    logic [CNT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_cipht;
    logic             r_err;
    logic [WIDTH-1:0] r_mm_a;
    logic [WIDTH-1:0] r_mm_b;

    logic             w_mul_skip;
    logic             w_last;
    logic             w_bit_step;
    logic [WIDTH-1:0] w_e_nxt;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_res_nxt;

`ifdef RSA_MODEXP_EARLY_EXIT_EN
    always_comb begin
        w_mul_skip = ~r_e_sh[0];
        w_e_nxt    = r_e_sh >> 1;
        w_idx_nxt  = r_idx + 1'b1;
        w_last     = (w_e_nxt == '0);
    end
`else
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH);

    always_comb begin
        w_mul_skip = 1'b0;
        w_e_nxt    = r_e_sh >> 1;
        w_idx_nxt  = r_idx + 1'b1;
        w_last     = (w_idx_nxt == LP_LAST);
    end
`endif

    // A skipped MUL has e_sh[0]==0, so this also yields the unchanged accumulator.
    always_comb begin
        w_res_nxt  = r_e_sh[0] ? mm_result : r_res;
        w_bit_step = ((r_state == S_MUL) && w_mul_skip) ||
                     ((r_state == S_MUL_WAIT) && mm_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_res   <= '0;
            r_base  <= '0;
            r_e_sh  <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_cipht <= '0;
            r_err   <= 1'b0;
            r_mm_a  <= '0;
            r_mm_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_vaild) begin
                        r_res   <= WIDTH'(1);
                        r_base  <= plaint;
                        r_e_sh  <= exp;
                        r_idx   <= '0;
                        r_n     <= n;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_n == '0 || r_base >= r_n) begin
                        r_cipht <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_e_sh == '0 || r_n == WIDTH'(1)) begin
                        r_cipht <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_mm_a  <= r_res;
                        r_mm_b  <= r_base;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (!w_mul_skip) begin
                        r_state <= S_MUL_WAIT;
                    end
                end
                S_MUL_WAIT: begin
                    if (mm_done) begin
                        r_res <= w_res_nxt;
                    end
                end
                S_SQR: begin
                    r_state <= S_SQR_WAIT;
                end
                S_SQR_WAIT: begin
                    if (mm_done) begin
                        r_base  <= mm_result;
                        r_mm_a  <= r_res;
                        r_mm_b  <= mm_result;
                        r_state <= S_MUL;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Shared end-of-bit bookkeeping for both the real and the skipped multiply.
            if (w_bit_step) begin
                r_e_sh <= w_e_nxt;
                r_idx  <= w_idx_nxt;
                if (w_last) begin
                    r_cipht <= w_res_nxt;
                    r_err   <= 1'b0;
                    r_state <= S_DONE;
                end else begin
                    r_mm_a  <= r_base;
                    r_mm_b  <= r_base;
                    r_state <= S_SQR;
                end
            end
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign vaild    = (r_state == S_DONE);
    assign cipht    = r_cipht;
    assign err      = r_err;
    assign mm_start = ((r_state == S_MUL) && !w_mul_skip) || (r_state == S_SQR);
    assign mm_a     = r_mm_a;
    assign mm_b     = r_mm_b;
    assign mm_n     = r_n;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl with a random-latency modular multiplier model.
module tb_rsa_modexp_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_vaild = 1'b0;
    logic [WIDTH-1:0] t_plaint = '0;
    logic [WIDTH-1:0] t_exp = '0;
    logic [WIDTH-1:0] t_n = '0;
    logic             ready;
    logic             vaild;
    logic [WIDTH-1:0] cipht;
    logic             err;
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_n;
    logic             mm_done = 1'b0;
    logic [WIDTH-1:0] mm_result = '0;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic             e;
        int               starts;
    } sb_entry_t;

    sb_entry_t sb[$];
    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int acc_cnt = 0;
    int force_lat = 0;
    logic prev_v = 1'b0;
    logic mm_abort = 1'b0;

    rsa_modexp_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_vaild(in_vaild),
        .plaint(t_plaint), .exp(t_exp), .n(t_n),
        .ready(ready), .vaild(vaild), .cipht(cipht), .err(err),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
        .mm_done(mm_done), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    // Left-to-right reference, independent of the controller's bit order.
    function automatic logic [WIDTH-1:0] ref_pow(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] e,
                                                 input logic [WIDTH-1:0] m);
        longint unsigned r, pp, mm;
        r = 1; pp = p; mm = m;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * pp) % mm;
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic sb_entry_t model(input logic [WIDTH-1:0] p,
                                        input logic [WIDTH-1:0] e,
                                        input logic [WIDTH-1:0] m);
        sb_entry_t s;
        int bl;
        if (m == 0 || p >= m) begin
            s.c = '0; s.e = 1'b1; s.starts = 0;
        end else if (e == 0 || m == 1) begin
            s.c = (m == 1) ? '0 : WIDTH'(1); s.e = 1'b0; s.starts = 0;
        end else begin
            s.c = ref_pow(p, e, m); s.e = 1'b0;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
            bl = 0;
            for (int i = 0; i < WIDTH; i++) if (e[i]) bl = i + 1;
            s.starts = $countones(e) + bl - 1;
`else
            bl = WIDTH;
            s.starts = 2 * bl - 1;
`endif
        end
        return s;
    endfunction

    // Monitor: scoreboard push on accept, pop on vaild.
    always @(negedge clk) begin
        sb_entry_t s;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (mm_start) start_cnt++;
            if (prev_v) begin
                check_eq("ready_after_vaild", ready, 1);
                check_eq("vaild_one_cycle", vaild, 0);
            end
            prev_v = vaild;
            if (vaild) begin
                if (sb.size() == 0) begin
                    check_eq("vaild_unexpected", vaild, 0);
                end else begin
                    s = sb.pop_front();
                    check_eq("cipht", cipht, s.c);
                    check_eq("err", err, s.e);
                    check_eq("mm_start_count", start_cnt, s.starts);
                end
            end
            if (in_vaild && ready) begin
                sb.push_back(model(t_plaint, t_exp, t_n));
                start_cnt = 0;
                acc_cnt++;
            end
        end
    end

    // Multiplier model: captures operands on mm_start, answers after 1..20 cycles.
    initial begin
        longint unsigned ca, cb, cn;
        int lat;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (mm_start && !reset) begin
                ca = mm_a; cb = mm_b; cn = mm_n;
                lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 20));
                mm_abort = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (reset) mm_abort = 1'b1;
                    if (!mm_abort) begin
                        check_eq("mm_a_stable", mm_a, ca);
                        check_eq("mm_b_stable", mm_b, cb);
                        check_eq("mm_n_stable", mm_n, cn);
                        check_eq("mm_start_while_busy", mm_start, 0);
                    end
                end
                mm_done = 1'b1;
                mm_result = (cn == 0) ? '0 : WIDTH'((ca * cb) % cn);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] e,
                        input logic [WIDTH-1:0] m);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!ready && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) check_eq("ready_timeout", ready, 1);
        in_vaild = 1'b1; t_plaint = p; t_exp = e; t_n = m;
        @(posedge clk); #1;
        in_vaild = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !ready) && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20000) check_eq("done_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, ready, 1);
        check_eq({tag, "_vaild"}, vaild, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_cipht"}, cipht, 0);
        check_eq({tag, "_mm_start"}, mm_start, 0);
        check_eq({tag, "_mm_abn"}, {mm_a, mm_b} | 64'(mm_n), 0);
    endtask

    initial begin
        int t;
        #2 reset = 1'b1;
        #1 check_reset_vals("rst");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(32'd4, 32'd3, 32'd10);
        wait_idle();
        send(32'd7, 32'd13, 32'd33);
        wait_idle();
        send(32'd4, 32'd7, 32'd33);
        send(32'd16, 32'd3, 32'd33);
        wait_idle();
        send(32'd5, 32'd0, 32'd10);
        send(32'd0, 32'd5, 32'd1);
        send(32'd3, 32'd5, 32'd0);
        send(32'd12, 32'd5, 32'd10);
        wait_idle();

        // Reset while the first square is outstanding; its late mm_done must be ignored.
        force_lat = 15;
        send(32'd4, 32'd3, 32'd10);
        t = 0;
        while (start_cnt < 2 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check_eq("sqr_wait_timeout", start_cnt, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        #1 check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (25) @(posedge clk);
        #1 check_reset_vals("postrst");
        force_lat = 0;
        send(32'd4, 32'd3, 32'd10);
        wait_idle();

        // in_vaild held high with operands changing every cycle.
        acc_cnt = 0;
        t = 0;
        in_vaild = 1'b1;
        while (acc_cnt < 6 && t < 40000) begin
            t_n = $urandom;
            if (t_n == 0) t_n = 32'd1;
            if ($urandom_range(0, 7) == 0) t_plaint = $urandom;
            else t_plaint = $urandom % t_n;
            t_exp = $urandom;
            @(posedge clk); #1;
            t++;
        end
        in_vaild = 1'b0;
        if (t >= 40000) check_eq("accept_timeout", acc_cnt, 6);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
